uart_tx_mmio: RTL



---
 rtl/uart_tx_mmio.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter on the CPU data bus.
//   BASE_ADDR+0  TXDATA  write pushes w_data_i[7:0] into the TX FIFO, reads 0
//   BASE_ADDR+4  STATUS  [0] full [1] empty [2] busy [3] overflow (sticky,
//                        write 1 to clear) [7:4] FIFO count [8] parity enabled
// Frames are 8N1 by default. Define UART_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit (8E1).
module uart_tx_mmio #(
  parameter int unsigned CLK_HZ     = 6000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] w_data_i,
  input  logic        w_ena_i,
  input  logic        r_ena_i,
  output logic [31:0] r_data_o,
  output logic        tx_o,
  output logic        busy_o
);

  // Bit period in clocks; the baud counter runs 0..DIV-1 inside every bit.
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [31:0]       TXDATA_ADDR = BASE_ADDR;
  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;
`else
  localparam logic PARITY_FLAG = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;
`endif

  // Transmit FSM state and bit timing
  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;

  // Transmit FIFO
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;

  logic              full;
  logic              empty;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              ovf_clr;
  logic              baud_tick;
  logic [7:0]        fifo_head;
  logic [31:0]       status;

  // Only the low byte of a store is transmitted.
  logic              unused_wdata;
  assign unused_wdata = ^w_data_i[31:8];

  // Bus decode and FIFO flags.
  always_comb begin
    full      = (count_q == CNT_FULL);
    empty     = (count_q == '0);
    push_req  = w_ena_i && (addr_i == TXDATA_ADDR);
    ovf_clr   = w_ena_i && (addr_i == STATUS_ADDR) && w_data_i[3];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push_ok   = push_req && (!full || pop);
    fifo_head = fifo_mem[rd_ptr_q];
    baud_tick = (baud_q == BAUD_LAST);
  end

  // Transmit FSM next state: framing, bit sequencing and FIFO pops.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    // The baud counter only runs while a frame is on the line.
    if (state_q == S_IDLE) begin
      baud_d = '0;
    end else if (baud_tick) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        bit_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (baud_tick) begin
          bit_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer, occupancy, overflow and busy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A dropped write sets the sticky flag; software clears it via STATUS.
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    // Built from next-state values so busy rises on the pushing edge.
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  // Control and framing registers; reset aborts any frame in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= w_data_i[7:0];
    end
  end

  // Serial line level; idle (and reset) is high.
  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      S_START:  tx_o = 1'b0;
      S_DATA:   tx_o = shift_q[bit_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_o = ^shift_q;
`endif
      default:  tx_o = 1'b1;
    endcase
  end

  // STATUS word and combinational read mux.
  always_comb begin
    status      = '0;
    status[0]   = full;
    status[1]   = empty;
    status[2]   = busy_q;
    status[3]   = ovf_q;
    status[7:4] = 4'(count_q);
    status[8]   = PARITY_FLAG;
    r_data_o    = (r_ena_i && (addr_i == STATUS_ADDR)) ? status : '0;
  end

  assign busy_o = busy_q;

endmodule
